// File: rtl/glb_psum_drain_pkg.sv
// Shared types and constants for the psum GLB drain engine and its skid FIFO.
package glb_psum_drain_pkg;

   localparam int unsigned DataBitwidthDef = 16;
   localparam int unsigned AddrBitwidthDef = 10;

   // Read data must always find a free slot: one entry per in-flight read plus one.
   localparam int unsigned MinSkidSlack = 1;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIssue  = 2'd1,
      StWait   = 2'd2,
      StFinish = 2'd3
   } drain_state_e;

   function automatic bit depth_ok(input int unsigned depth, input int unsigned lat);
      return depth >= lat + MinSkidSlack;
   endfunction

endpackage

// File: rtl/psum_skid_fifo.sv
// Synchronous FIFO with push/pop/count/full/empty; push on full is legal only with a pop.
module psum_skid_fifo #(
   parameter int unsigned Width = 16,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic [CntW-1:0]  count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(Depth));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && full_o && !pop_i))
      else $error("psum_skid_fifo overflow");

endmodule

// File: rtl/glb_psum_drain.sv
// Psum GLB reader: on start, reads a programmed address window and streams it out valid/ready.
// Optional PSUM_DRAIN_RELU_EN clamps negative words to zero at the FIFO output.
module glb_psum_drain
   import glb_psum_drain_pkg::*;
#(
   parameter int unsigned DataBitwidth = DataBitwidthDef,
   parameter int unsigned AddrBitwidth = AddrBitwidthDef,
   parameter int unsigned GlbRdLatency = 1,
   parameter int unsigned FifoDepth    = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic        [AddrBitwidth-1:0] base_addr_i,
   input  logic        [AddrBitwidth-1:0] num_words_i,
   output logic                           read_req_psum_o,
   output logic        [AddrBitwidth-1:0] r_addr_psum_o,
   input  logic signed [DataBitwidth-1:0] r_data_psum_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic signed [DataBitwidth-1:0] out_data_o,
   output logic                           out_last_o,
   output logic                           busy_o,
   output logic                           done_o
);

   localparam int unsigned CntW  = $clog2(FifoDepth + 1);
   localparam int unsigned InflW = $clog2(GlbRdLatency + 1);
   localparam bit          DepthOk = depth_ok(FifoDepth, GlbRdLatency);

   drain_state_e            state_q, state_d;
   logic [AddrBitwidth-1:0] base_q, base_d, num_q, num_d;
   logic [AddrBitwidth-1:0] issued_q, issued_d, accepted_q, accepted_d;
   logic [AddrBitwidth-1:0] addr_q, issue_addr;
   logic [GlbRdLatency-1:0] vld_q;
   logic [InflW-1:0]        inflight;
   logic                    req, credit_ok;

   logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CntW-1:0]         fifo_count;
   logic [DataBitwidth-1:0] fifo_head, head_out;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < GlbRdLatency; i++) inflight = inflight + InflW'(vld_q[i]);
   end

   // Reserve a FIFO slot for every read still in the GLB pipeline.
   assign credit_ok  = (32'(inflight) + 32'(fifo_count)) < FifoDepth;
   assign issue_addr = base_q + issued_q;
   assign fifo_push  = vld_q[GlbRdLatency-1];
   assign fifo_pop   = out_valid_o && out_ready_i;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      num_d      = num_q;
      issued_d   = issued_q;
      accepted_d = fifo_pop ? accepted_q + 1'b1 : accepted_q;
      req        = 1'b0;
      done_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               base_d     = base_addr_i;
               num_d      = num_words_i;
               issued_d   = '0;
               accepted_d = '0;
               state_d    = (num_words_i == '0) ? StFinish : StIssue;
            end
         end
         StIssue: begin
            if (credit_ok) begin
               req      = 1'b1;
               issued_d = issued_q + 1'b1;
               if (issued_d == num_q) state_d = StWait;
            end
         end
         StWait: begin
            if (fifo_pop && out_last_o) state_d = StFinish;
         end
         StFinish: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         base_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         accepted_q <= '0;
         addr_q     <= '0;
         vld_q      <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         num_q      <= num_d;
         issued_q   <= issued_d;
         accepted_q <= accepted_d;
         if (req) addr_q <= issue_addr;
         vld_q[0] <= req;
         for (int i = 1; i < GlbRdLatency; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   psum_skid_fifo #(
      .Width (DataBitwidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .wdata_i (r_data_psum_i),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef PSUM_DRAIN_RELU_EN
   assign head_out = fifo_head[DataBitwidth-1] ? '0 : fifo_head;
`else
   assign head_out = fifo_head;
`endif

   assign read_req_psum_o = req;
   assign r_addr_psum_o   = req ? issue_addr : addr_q;
   assign out_valid_o     = !fifo_empty;
   assign out_data_o      = out_valid_o ? head_out : '0;
   assign out_last_o      = out_valid_o && (accepted_q == num_q - 1'b1);
   assign busy_o          = (state_q != StIdle);

   credit_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fifo_push && fifo_full && !fifo_pop))
      else $error("glb_psum_drain credit violation");

   depth_a: assert property (@(posedge clk_i) DepthOk)
      else $error("glb_psum_drain FifoDepth too small for GlbRdLatency");

endmodule

// File: tb/tb_glb_psum_drain.sv
// Directed bench: instance A (latency 1, always ready) and B (latency 3, ready 1,0,0,1).
module tb_glb_psum_drain;

   localparam int DW = 16;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start;
   logic [AW-1:0] base, num;
   logic rdy_a, rdy_b;
   int   cyc = 0;
   int   checks = 0, failures = 0;

   logic req_a, val_a, last_a, busy_a, done_a;
   logic req_b, val_b, last_b, busy_b, done_b;
   logic [AW-1:0] addr_a, addr_b;
   logic signed [DW-1:0] rdata_a, rdata_b, data_a, data_b;
   logic signed [DW-1:0] mem [1024];
   logic signed [DW-1:0] pa1, pb1, pb2, pb3;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1 rdy_b = ((cyc % 4) == 0) || ((cyc % 4) == 3);
   end
   assign rdy_a = 1'b1;

   // GLB models: registered read, then extra pipeline stages for B.
   always @(posedge clk) begin
      pa1 <= mem[addr_a];
      pb1 <= mem[addr_b];
      pb2 <= pb1;
      pb3 <= pb2;
   end
   assign rdata_a = pa1;
   assign rdata_b = pb3;

   glb_psum_drain #(.DataBitwidth(DW), .AddrBitwidth(AW), .GlbRdLatency(1), .FifoDepth(4)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base), .num_words_i(num),
      .read_req_psum_o(req_a), .r_addr_psum_o(addr_a), .r_data_psum_i(rdata_a),
      .out_valid_o(val_a), .out_ready_i(rdy_a), .out_data_o(data_a), .out_last_o(last_a),
      .busy_o(busy_a), .done_o(done_a)
   );

   glb_psum_drain #(.DataBitwidth(DW), .AddrBitwidth(AW), .GlbRdLatency(3), .FifoDepth(4)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base), .num_words_i(num),
      .read_req_psum_o(req_b), .r_addr_psum_o(addr_b), .r_data_psum_i(rdata_b),
      .out_valid_o(val_b), .out_ready_i(rdy_b), .out_data_o(data_b), .out_last_o(last_b),
      .busy_o(busy_b), .done_o(done_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   // Monitors only append; scenarios slice from marks taken before they start.
   int wd_a[$], wl_a[$], ac_a[$], adr_a[$], rc_a[$], dn_a[$];
   int wd_b[$], wl_b[$], adr_b[$], dn_b[$];
   logic stall_b = 1'b0;
   logic [DW+1:0] held_b;

   always @(negedge clk) begin
      if (rst_n) begin
         if (req_a) begin adr_a.push_back(int'(addr_a)); rc_a.push_back(cyc); end
         if (val_a && rdy_a) begin
            wd_a.push_back(int'(data_a)); wl_a.push_back(int'(last_a)); ac_a.push_back(cyc);
         end
         if (done_a) dn_a.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_b) check_eq("stable_b", {14'd0, val_b, last_b, data_b}, {14'd0, held_b});
         if (req_b) adr_b.push_back(int'(addr_b));
         if (val_b && rdy_b) begin wd_b.push_back(int'(data_b)); wl_b.push_back(int'(last_b)); end
         if (done_b) dn_b.push_back(cyc);
         stall_b = val_b && !rdy_b;
         held_b  = {val_b, last_b, data_b};
      end else begin
         stall_b = 1'b0;
      end
   end

   int m_w_a, m_w_b, m_r_a, m_r_b, m_d_a, m_d_b;

   task automatic mark();
      m_w_a = wd_a.size(); m_w_b = wd_b.size(); m_r_a = adr_a.size();
      m_r_b = adr_b.size(); m_d_a = dn_a.size(); m_d_b = dn_b.size();
   endtask

   task automatic pulse(input int a, input int n, output int s);
      @(negedge clk);
      base = AW'(a); num = AW'(n); start = 1'b1; s = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while ((dn_a.size() == m_d_a || dn_b.size() == m_d_b) && n < limit) begin
         @(negedge clk); n++;
      end
      check_eq("done_seen", 32'((dn_a.size() > m_d_a) && (dn_b.size() > m_d_b)), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_stream(input string tag, input int exp[$], input int d[$], input int l[$],
                               input int m);
      check_eq({tag, "_count"}, d.size() - m, exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         if (m + i < d.size()) begin
            check_eq($sformatf("%s_w%0d", tag, i), d[m+i], exp[i]);
            check_eq($sformatf("%s_last%0d", tag, i), l[m+i], int'(i == exp.size() - 1));
         end
      end
   endtask

   initial begin
      int s, n;
      int e[$];
      int wexp[$];
      start = 1'b0; base = '0; num = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_outs_a", {1'b0, req_a, addr_a, val_a, data_a, last_a, busy_a, done_a}, 0);
      check_eq("rst_outs_b", {1'b0, req_b, addr_b, val_b, data_b, last_b, busy_b, done_b}, 0);
      rst_n = 1'b1;

      // Basic drain and backpressure
      e = {};
      for (int i = 0; i < 9; i++) begin mem[500+i] = DW'(16'h10 + i); e.push_back(16'h10 + i); end
      mark();
      pulse(500, 9, s);
      wait_done(300);
      check_stream("basic_a", e, wd_a, wl_a, m_w_a);
      check_stream("bp_b", e, wd_b, wl_b, m_w_b);
      check_eq("basic_back2back", ac_a[ac_a.size()-1] - ac_a[m_w_a], 8);
      check_eq("basic_done_lat", dn_a[m_d_a] - ac_a[ac_a.size()-1], 1);
      check_eq("basic_first_valid", ac_a[m_w_a] - rc_a[m_r_a], 2);
      check_eq("done_once_a", dn_a.size() - m_d_a, 1);
      check_eq("done_once_b", dn_b.size() - m_d_b, 1);
      check_eq("idle_after", {busy_a, busy_b}, 0);

      // Address wrap
      e = {32'h100, 32'h101, 32'h102, 32'h103};
      mem[1022] = 16'h100; mem[1023] = 16'h101; mem[0] = 16'h102; mem[1] = 16'h103;
      wexp = {1022, 1023, 0, 1};
      mark();
      pulse(1022, 4, s);
      wait_done(300);
      check_eq("wrap_nreq_a", adr_a.size() - m_r_a, 4);
      check_eq("wrap_nreq_b", adr_b.size() - m_r_b, 4);
      for (int i = 0; i < 4; i++) begin
         if (m_r_a + i < adr_a.size()) check_eq($sformatf("wrap_addr_a%0d", i), adr_a[m_r_a+i], wexp[i]);
         if (m_r_b + i < adr_b.size()) check_eq($sformatf("wrap_addr_b%0d", i), adr_b[m_r_b+i], wexp[i]);
      end
      check_stream("wrap_a", e, wd_a, wl_a, m_w_a);

      // Zero length
      mark();
      pulse(40, 0, s);
      repeat (3) @(negedge clk);
      check_eq("zero_noreq", (adr_a.size() - m_r_a) + (adr_b.size() - m_r_b), 0);
      check_eq("zero_done_n", dn_a.size() - m_d_a, 1);
      if (dn_a.size() > m_d_a) check_eq("zero_done_lat", dn_a[m_d_a] - s, 1);
      check_eq("zero_idle", {busy_a, busy_b}, 0);

      // Start while busy is ignored
      e = {};
      for (int i = 0; i < 5; i++) begin mem[200+i] = DW'(i + 1); e.push_back(i + 1); end
      mark();
      pulse(200, 5, s);
      repeat (3) @(negedge clk);
      pulse(300, 2, s);
      wait_done(300);
      repeat (10) @(negedge clk);
      check_stream("ign_a", e, wd_a, wl_a, m_w_a);
      check_stream("ign_b", e, wd_b, wl_b, m_w_b);
      check_eq("ign_done_a", dn_a.size() - m_d_a, 1);
      check_eq("ign_done_b", dn_b.size() - m_d_b, 1);

      // Reset mid-drain
      mark();
      pulse(500, 9, s);
      n = 0;
      while (wd_a.size() - m_w_a < 3 && n < 100) begin @(posedge clk); #1; n++; end
      check_eq("rst_reach3", wd_a.size() - m_w_a, 3);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_a", {1'b0, req_a, addr_a, val_a, data_a, last_a, busy_a, done_a}, 0);
      check_eq("mid_rst_b", {1'b0, req_b, addr_b, val_b, data_b, last_b, busy_b, done_b}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_no_done", (dn_a.size() - m_d_a) + (dn_b.size() - m_d_b), 0);
      e = {};
      for (int i = 0; i < 9; i++) e.push_back(16'h10 + i);
      mark();
      pulse(500, 9, s);
      wait_done(300);
      check_stream("rerun_a", e, wd_a, wl_a, m_w_a);
      check_stream("rerun_b", e, wd_b, wl_b, m_w_b);

      // Signed data, optional ReLU
      mem[0] = -16'sd5; mem[1] = 16'sd7; mem[2] = -16'sd32768;
`ifdef PSUM_DRAIN_RELU_EN
      e = {0, 7, 0};
`else
      e = {-5, 7, -32768};
`endif
      mark();
      pulse(0, 3, s);
      wait_done(300);
      check_stream("relu_a", e, wd_a, wl_a, m_w_a);
      check_stream("relu_b", e, wd_b, wl_b, m_w_b);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
